// File: rtl/reflet_mailbox_pkg.sv
// reflet_mailbox_pkg: register offsets and bit positions shared by the mailbox block and its users.
package reflet_mailbox_pkg;
  localparam logic [1:0] MAILBOX_PUSH = 2'd0;
  localparam logic [1:0] MAILBOX_HEAD = 2'd1;
  localparam logic [1:0] MAILBOX_STATUS = 2'd2;
  localparam logic [1:0] MAILBOX_CONTROL = 2'd3;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_UNDERFLOW = 3;
  localparam int ST_COUNT = 4;
  // CONTROL flag positions counted down from the MSB: bit index = wordsize - offset
  localparam int CTRL_IRQ_EN_OFS = 1;
  localparam int CTRL_CLEAR_OFS = 2;
endpackage

// File: rtl/reflet_mailbox_if.sv
// reflet_mailbox_if: reflet_cpu peripheral bus as seen by one responder.
interface reflet_mailbox_if #(parameter int wordsize = 16, parameter int addrSize = 2);
  logic enable;
  logic write_en;
  logic irq;
  logic [addrSize-1:0] addr;
  logic [wordsize-1:0] data_in;
  logic [wordsize-1:0] data_out;
  modport master(output enable, addr, data_in, write_en, input data_out, irq);
  modport slave(input enable, addr, data_in, write_en, output data_out, irq);
endinterface

// File: rtl/reflet_mailbox_fifo.sv
// reflet_mailbox_fifo: circular word buffer with occupancy count and failed push/pop pulses.
module reflet_mailbox_fifo
  import reflet_mailbox_pkg::*;
#(parameter int wordsize = 16, parameter int depthLog2 = 3) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  logic [wordsize-1:0] din,
  output logic [wordsize-1:0] head,
  output logic [depthLog2:0] count,
  output logic [depthLog2:0] count_d,
  output logic full,
  output logic empty,
  output logic push_fail,
  output logic pop_fail
);
  logic [wordsize-1:0] mem [1<<depthLog2];
  logic [depthLog2-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  // count never exceeds the depth, so its MSB alone means full
  assign full = count[depthLog2];
  assign empty = count == '0;
  assign push_fail = push && full;
  assign pop_fail = pop && empty;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  assign count_d = clear ? '0 : do_push ? count + (depthLog2+1)'(1) : do_pop ? count - (depthLog2+1)'(1) : count;
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + depthLog2'(1);
      if (do_pop) rd_ptr <= rd_ptr + depthLog2'(1);
    end
    count <= reset ? count_d : '0;
  end
  always_ff @(posedge clk) if (reset && do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/reflet_mailbox.sv
// reflet_mailbox: memory-mapped FIFO mailbox bus responder for reflet_cpu.
// Define REFLET_MAILBOX_IRQ_EN for the registered threshold/overflow interrupt; otherwise irq is tied low.
module reflet_mailbox
  import reflet_mailbox_pkg::*;
#(parameter int wordsize = 16, parameter int depthLog2 = 3, parameter int addrSize = 2) (
  input logic clk,
  input logic reset,
  reflet_mailbox_if.slave bus
);
  localparam int IRQ_BIT = wordsize - CTRL_IRQ_EN_OFS;
  localparam int CLR_BIT = wordsize - CTRL_CLEAR_OFS;
  logic [addrSize-1:0] addr;
  logic [1:0] sel;
  logic wr, push, pop, ctrl_wr, clear;
  logic [wordsize-1:0] head, status, control, rd_d;
  logic [depthLog2:0] count, count_d, thr, thr_d;
  logic full, empty, push_fail, pop_fail, ovf, ovf_d, unf, unf_d, irq_en;
  assign addr = bus.addr;
  assign sel = addr[1:0];
  assign wr = bus.enable && bus.write_en;
  assign push = wr && sel == MAILBOX_PUSH;
  assign pop = wr && sel == MAILBOX_HEAD;
  assign ctrl_wr = wr && sel == MAILBOX_CONTROL;
  assign clear = ctrl_wr && bus.data_in[CLR_BIT];
  reflet_mailbox_fifo #(.wordsize(wordsize), .depthLog2(depthLog2)) fifo (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop), .din(bus.data_in),
    .head(head), .count(count), .count_d(count_d), .full(full), .empty(empty),
    .push_fail(push_fail), .pop_fail(pop_fail)
  );
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVERFLOW] = ovf;
    status[ST_UNDERFLOW] = unf;
    status[ST_COUNT +: depthLog2+1] = count;
    control = '0;
    control[depthLog2:0] = thr;
    control[IRQ_BIT] = irq_en;
    thr_d = ctrl_wr ? bus.data_in[depthLog2:0] : thr;
    ovf_d = !clear && (ovf || push_fail);
    unf_d = !clear && (unf || pop_fail);
    // stale storage stays hidden: HEAD of an empty FIFO always reads 0
    rd_d = !bus.enable ? '0 : sel == MAILBOX_HEAD ? (empty ? '0 : head) :
           sel == MAILBOX_STATUS ? status : sel == MAILBOX_CONTROL ? control : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      thr <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      bus.data_out <= '0;
    end else begin
      thr <= thr_d;
      ovf <= ovf_d;
      unf <= unf_d;
      bus.data_out <= rd_d;
    end
  end
`ifdef REFLET_MAILBOX_IRQ_EN
  logic irq_en_d, irq_q;
  assign irq_en_d = ctrl_wr ? bus.data_in[IRQ_BIT] : irq_en;
  always_ff @(posedge clk) begin
    irq_en <= reset && irq_en_d;
    irq_q <= reset && irq_en_d && (count_d >= thr_d || ovf_d);
  end
  assign bus.irq = irq_q;
`else
  logic unused_count_d;
  assign unused_count_d = ^count_d;
  assign irq_en = 1'b0;
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_reflet_mailbox.sv
// tb_reflet_mailbox: directed plus randomized bus traffic scored against a queue-based mailbox model.
module tb_reflet_mailbox;
  import reflet_mailbox_pkg::*;
  typedef struct {
    logic [15:0] d;
    logic irq;
  } exp_t;
`ifdef REFLET_MAILBOX_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  reflet_mailbox_if #(.wordsize(16), .addrSize(2)) bus();
  reflet_mailbox dut(.clk(clk), .reset(reset), .bus(bus));
  exp_t exp_q[$];
  exp_t got;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] m_q[$];
  logic m_ovf = 1'b0, m_unf = 1'b0, m_ien = 1'b0;
  logic [3:0] m_thr = 4'h0;

  function automatic logic [15:0] m_read(logic [1:0] a);
    int n = m_q.size();
    case (a)
      MAILBOX_HEAD: return n == 0 ? 16'h0 : m_q[0];
      MAILBOX_STATUS: return {8'h0, 4'(n), m_unf, m_ovf, n == 8, n == 0};
      MAILBOX_CONTROL: return {m_ien, 11'h0, m_thr};
      default: return 16'h0;
    endcase
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, act, expv);
    end
  endtask

  task automatic cycle(logic rn, logic en, logic we, logic [1:0] a, logic [15:0] d);
    exp_t e;
    @(negedge clk);
    reset = rn;
    bus.enable = en;
    bus.write_en = we;
    bus.addr = a;
    bus.data_in = d;
    e.d = (rn && en) ? m_read(a) : 16'h0;
    if (!rn) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ien = 1'b0;
      m_thr = 4'h0;
    end else if (en && we) begin
      case (a)
        MAILBOX_PUSH: if (m_q.size() == 8) m_ovf = 1'b1; else m_q.push_back(d);
        MAILBOX_HEAD: if (m_q.size() == 0) m_unf = 1'b1; else void'(m_q.pop_front());
        MAILBOX_CONTROL: begin
          m_thr = d[3:0];
          m_ien = IRQ_ON && d[15];
          if (d[14]) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
          end
        end
        default: ;
      endcase
    end
    e.irq = m_ien && (m_q.size() >= int'(m_thr) || m_ovf);
    exp_q.push_back(e);
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    cycle(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(logic [1:0] a);
    cycle(1'b1, 1'b1, 1'b0, a, 16'($urandom));
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      cyc++;
      check("data_out", bus.data_out, got.d);
      check("irq", {15'h0, bus.irq}, {15'h0, got.irq});
    end
  end

  initial begin
    logic [15:0] d;
    logic [1:0] a;
    bus.enable = 1'b0;
    bus.write_en = 1'b0;
    bus.addr = 2'd0;
    bus.data_in = 16'h0;
    repeat (2) cycle(1'b0, 1'b1, 1'b0, MAILBOX_STATUS, 16'h0);
    rd(MAILBOX_STATUS);
    wr(MAILBOX_PUSH, 16'h1111);
    wr(MAILBOX_PUSH, 16'h2222);
    wr(MAILBOX_PUSH, 16'h3333);
    rd(MAILBOX_STATUS);
    repeat (3) begin
      rd(MAILBOX_HEAD);
      wr(MAILBOX_HEAD, 16'h0);
    end
    rd(MAILBOX_STATUS);
    for (int i = 0; i < 8; i++) wr(MAILBOX_PUSH, 16'hA000 + 16'(i));
    rd(MAILBOX_STATUS);
    wr(MAILBOX_PUSH, 16'hBEEF);
    rd(MAILBOX_STATUS);
    repeat (8) begin
      rd(MAILBOX_HEAD);
      wr(MAILBOX_HEAD, 16'($urandom));
    end
    rd(MAILBOX_STATUS);
    wr(MAILBOX_HEAD, 16'h0);
    rd(MAILBOX_STATUS);
    wr(MAILBOX_CONTROL, 16'h4000);
    rd(MAILBOX_STATUS);
    wr(MAILBOX_PUSH, 16'h5555);
    rd(MAILBOX_HEAD);
    idle();
    idle();
    wr(MAILBOX_CONTROL, 16'h8002);
    rd(MAILBOX_CONTROL);
    wr(MAILBOX_PUSH, 16'h0001);
    idle();
    wr(MAILBOX_PUSH, 16'h0002);
    idle();
    wr(MAILBOX_HEAD, 16'h0);
    idle();
    wr(MAILBOX_PUSH, 16'h0003);
    cycle(1'b0, 1'b1, 1'b1, MAILBOX_PUSH, 16'h0004);
    rd(MAILBOX_STATUS);
    rd(MAILBOX_HEAD);
    wr(MAILBOX_CONTROL, 16'h8000);
    idle();
    for (int i = 0; i < 800; i++) begin
      a = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      if (a == MAILBOX_CONTROL) d[14] = ($urandom_range(0, 7) == 0);
      cycle(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), a, d);
    end
    rd(MAILBOX_STATUS);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reflet_mailbox.md
Name: reflet_mailbox

Overview:
- Memory-mapped FIFO peripheral that acts as a bus responder for reflet_cpu, on the same addr / data_in / data_out / write_en / enable bus used by reflet_ram16.
- Lets the CPU, or a second bus initiator sharing the decode, queue words and drain them later.
- Read data is registered, with one-cycle latency, and is zero when the block is not selected, so it can be ORed onto the shared data bus.

Parameters:
- wordsize, 16, data bus width and FIFO word width.
- depthLog2, 3, FIFO depth is 2^depthLog2 words.
- addrSize, 2, width of the register-select address; only addr[1:0] are decoded.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- enable  input  1  chip select from the address decoder.
- addr  input  addrSize  register offset.
- data_in  input  wordsize  write data from the CPU.
- write_en  input  1  write strobe; the CPU asserts it for exactly one cycle per store.
- data_out  output  wordsize  registered read data; 0 when not selected.
- irq  output  1  level interrupt request to reflet_cpu ext_int.

Behaviour:
- Register map, with writes accepted when enable && write_en:
  - Offset 0, PUSH: a write pushes data_in. A read returns 0.
  - Offset 1, HEAD: a read returns the oldest word without popping (0 if empty). A write of any value pops one word.
  - Offset 2, STATUS, read-only: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), bits[4+depthLog2:4] count (0..2^depthLog2). Other bits are 0.
  - Offset 3, CONTROL:
    - bits[depthLog2:0] threshold.
    - bit[wordsize-1] irq enable.
    - Writing with bit[wordsize-2]=1 clears the FIFO and both sticky flags; the stored control fields still update.
- Read timing: data_out is registered. The value for (enable, addr) sampled at edge N appears after edge N and holds until edge N+1. If enable=0 at edge N, data_out is 0 after it.
- Reads have no side effects.
- FIFO: circular buffer, rd_ptr/wr_ptr of width depthLog2 that wrap modulo depth, plus a count of width depthLog2+1.
- Push when full: data is discarded, pointers are unchanged, overflow is set.
- Pop when empty: no change, underflow is set.
- Clear and PUSH are single-address accesses, so they cannot occur in the same cycle.
- Reset (reset==0 at a clock edge), including in the middle of an operation:
  - pointers, count, sticky flags, threshold and irq enable go to 0;
  - data_out=0, irq=0;
  - FIFO storage contents are not cleared.
- Reading HEAD in the same cycle as a PUSH into an empty FIFO returns 0; the new word becomes visible on the next access.

Optional Feature:
- REFLET_MAILBOX_IRQ_EN defined:
  - irq is registered: irq = irqEnable && (count >= threshold || overflow), computed from the state after the current edge.
  - irq has one cycle of latency relative to the triggering write.
  - threshold 0 with irq enable set keeps irq asserted.
- REFLET_MAILBOX_IRQ_EN undefined: irq is tied to 0, and CONTROL bit[wordsize-1] reads back as 0.

Decomposition:
- Shared package/header holds:
  - offset constants MAILBOX_PUSH=0, MAILBOX_HEAD=1, MAILBOX_STATUS=2, MAILBOX_CONTROL=3;
  - STATUS bit indices;
  - CONTROL clear and irq-enable bit positions.
- One sub-module, reflet_mailbox_fifo: storage, pointers, count, full/empty, plus push_fail/pop_fail pulses.
- The top level does address decode, status/control registers, read mux and irq.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> data_out=0, irq=0; STATUS reads 0x0001 (empty only).
- Ordering: push 0x1111, 0x2222, 0x3333 -> STATUS count=3. Then repeat "read HEAD, write HEAD" three times -> reads 0x1111, 0x2222, 0x3333, then STATUS=0x0001.
- Wrap and overflow (depthLog2=3): push 8 words 0xA000..0xA007 -> full, count=8. Push 0xBEEF -> overflow set. Pop 8 -> words returned in order with no 0xBEEF; STATUS = empty | overflow.
- Underflow: pop when empty -> underflow bit set, count stays 0. Write CONTROL with the clear bit -> STATUS=0x0001.
- Read latency and bus isolation: read HEAD with enable=1 for one cycle, then enable=0 -> data_out valid for exactly one cycle, then 0.
- IRQ (with REFLET_MAILBOX_IRQ_EN): CONTROL = irq enable, threshold=2. Push one word -> irq=0. Push a second -> irq=1 on the next cycle. Pop one -> irq=0 one cycle later. Drop reset mid-sequence -> irq=0 and FIFO empty.
